online_adder_rk: RTL and testbench

ONLINE_ADDER_RK -- requirements
Module: online_adder_rk

---
 rtl/online_adder_rk.sv | 115 +++++++++++
 tb/tb_online_adder_rk.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/online_adder_rk.sv
// online_adder_rk: radix-2^K MSD-first online signed-digit adder, online delay 1.
// Define ONLINE_ADDER_RANGE_CHECK_EN to add a sticky range_err flag for out-of-range operand digits.
module online_adder_rk #(
    parameter int K = 2,
    parameter int A = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_first,
    input  logic              in_last,
    input  logic signed [K:0] x_digit,
    input  logic signed [K:0] y_digit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic signed [K:0] out_digit,
    output logic              out_last
`ifdef ONLINE_ADDER_RANGE_CHECK_EN
    ,
    output logic              range_err
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic signed [K+1:0] AS  = (K+2)'(A);
    localparam logic signed [K:0]   ONE = (K+1)'(1);

    state_t            state_q, state_d;
    logic signed [K:0] w_q, w_d, digit_q, digit_d;
    logic              valid_q, valid_d, last_q, last_d;
    logic signed [K+1:0] xe, ye, p;
    logic signed [K:0] w, t, z_run;
    logic              t_pos, t_neg, can_load, accept;

    assign xe       = {x_digit[K], x_digit};
    assign ye       = {y_digit[K], y_digit};
    assign p        = xe + ye;
    assign t_pos    = p >= AS;
    assign t_neg    = p <= -AS;
    assign t        = t_pos ? ONE : t_neg ? -ONE : '0;
    // Adding or subtracting r = 2^K modulo 2^(K+1) is a flip of the top bit.
    assign w        = {p[K] ^ (t_pos | t_neg), p[K-1:0]};
    assign z_run    = w_q + t;
    assign can_load = !valid_q || out_ready;
    assign in_ready = (state_q != FLUSH) && can_load;
    assign accept   = in_valid && in_ready;

    assign out_valid = valid_q;
    assign out_digit = digit_q;
    assign out_last  = last_q;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        digit_d = digit_q;
        last_d  = last_q;
        valid_d = valid_q && !out_ready;
        case (state_q)
            IDLE: if (accept && in_first) begin
                digit_d = t;
                w_d     = w;
                valid_d = 1'b1;
                last_d  = 1'b0;
                state_d = in_last ? FLUSH : RUN;
            end
            RUN: if (accept) begin
                digit_d = z_run;
                w_d     = w;
                valid_d = 1'b1;
                last_d  = 1'b0;
                state_d = in_last ? FLUSH : RUN;
            end
            FLUSH: if (can_load) begin
                digit_d = w_q;
                valid_d = 1'b1;
                last_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            w_q     <= '0;
            digit_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

`ifdef ONLINE_ADDER_RANGE_CHECK_EN
    logic bad, err_q, err_d;

    assign bad   = (xe > AS) || (xe < -AS) || (ye > AS) || (ye < -AS);
    assign err_d = !accept ? err_q
                 : (state_q == IDLE && in_first && !bad) ? 1'b0
                 : bad ? 1'b1 : err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign range_err = err_q;
`endif
endmodule

// File: tb/tb_online_adder_rk.sv
// tb_online_adder_rk: directed self-checking bench for online_adder_rk (K=2, A=3).
module tb_online_adder_rk;
    localparam int K = 2;
    localparam int A = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic signed [K:0] x_digit = '0, y_digit = '0;
    logic              in_ready, out_valid, out_last;
    logic signed [K:0] out_digit;
`ifdef ONLINE_ADDER_RANGE_CHECK_EN
    logic              range_err;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int got_d[$];
    bit got_l[$];

    online_adder_rk #(.K(K), .A(A)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last),
        .x_digit(x_digit), .y_digit(y_digit),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_digit(out_digit), .out_last(out_last)
`ifdef ONLINE_ADDER_RANGE_CHECK_EN
        , .range_err(range_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transfers are decided by values stable across the half cycle before the edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            got_d.push_back(int'(out_digit));
            got_l.push_back(out_last);
        end
    end

    task automatic beat(input int x, input int y, input bit f, input bit l);
        bit ok = 1'b0;
        x_digit  = (K+1)'(x);
        y_digit  = (K+1)'(y);
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL beat_accept: in_ready=0 for 50 cycles, required 1"); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_digit !== 0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b digit=%0d last=%b, required 0 0 0", out_valid, out_digit, out_last);
        end
`ifdef ONLINE_ADDER_RANGE_CHECK_EN
        n_checks++;
        if (range_err !== 1'b0) begin n_fail++; $display("FAIL reset_range_err: got %b, required 0", range_err); end
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_basic();
        int ed[$] = '{1, 3, 2};
        bit el[$] = '{0, 0, 1};
        got_d.delete(); got_l.delete();
        beat(3, 3, 1, 0);
        n_checks++;
        if (out_valid !== 1'b1 || out_digit !== 1) begin
            n_fail++;
            $display("FAIL basic_latency: valid=%b digit=%0d, required 1 1", out_valid, out_digit);
        end
        beat(3, 3, 0, 1);
        drain();
        n_checks++;
        if (got_d.size() != ed.size()) begin n_fail++; $display("FAIL basic_count: got %0d digits, required %0d", got_d.size(), ed.size()); end
        for (int i = 0; i < ed.size() && i < got_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== ed[i] || got_l[i] !== el[i]) begin
                n_fail++;
                $display("FAIL basic_digit%0d: got %0d last=%b, required %0d last=%b", i, got_d[i], got_l[i], ed[i], el[i]);
            end
        end
    endtask

    task automatic test_negative();
        int ed[$] = '{-1, -1, 1};
        bit el[$] = '{0, 0, 1};
        got_d.delete(); got_l.delete();
        beat(-3, -2, 1, 0);
        beat(0, 1, 0, 1);
        drain();
        n_checks++;
        if (got_d.size() != ed.size()) begin n_fail++; $display("FAIL neg_count: got %0d digits, required %0d", got_d.size(), ed.size()); end
        for (int i = 0; i < ed.size() && i < got_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== ed[i] || got_l[i] !== el[i]) begin
                n_fail++;
                $display("FAIL neg_digit%0d: got %0d last=%b, required %0d last=%b", i, got_d[i], got_l[i], ed[i], el[i]);
            end
        end
    endtask

    task automatic test_discard_single();
        int ed[$] = '{1, -1};
        bit el[$] = '{0, 1};
        got_d.delete(); got_l.delete();
        beat(3, 3, 0, 0);
        drain();
        n_checks++;
        if (got_d.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL discard: got %0d digits valid=%b, required 0 0", got_d.size(), out_valid);
        end
        beat(2, 1, 1, 1);
        drain();
        n_checks++;
        if (got_d.size() != ed.size()) begin n_fail++; $display("FAIL single_count: got %0d digits, required %0d", got_d.size(), ed.size()); end
        for (int i = 0; i < ed.size() && i < got_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== ed[i] || got_l[i] !== el[i]) begin
                n_fail++;
                $display("FAIL single_digit%0d: got %0d last=%b, required %0d last=%b", i, got_d[i], got_l[i], ed[i], el[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int ed[$] = '{1, 1, 0, -1, 0};
        bit el[$] = '{0, 0, 0, 0, 1};
        got_d.delete(); got_l.delete();
        beat(3, 3, 1, 0);
        beat(-3, -2, 0, 0);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_digit !== 1) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: in_ready=%b valid=%b digit=%0d, required 0 1 1", c, in_ready, out_valid, out_digit);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        beat(2, 1, 0, 0);
        beat(0, 0, 0, 1);
        drain();
        n_checks++;
        if (got_d.size() != ed.size()) begin n_fail++; $display("FAIL stall_count: got %0d digits, required %0d", got_d.size(), ed.size()); end
        for (int i = 0; i < ed.size() && i < got_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== ed[i] || got_l[i] !== el[i]) begin
                n_fail++;
                $display("FAIL stall_digit%0d: got %0d last=%b, required %0d last=%b", i, got_d[i], got_l[i], ed[i], el[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int ed[$] = '{-1, -1, 1};
        bit el[$] = '{0, 0, 1};
        beat(3, 3, 1, 0);
        beat(-3, -2, 0, 0);
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_digit !== 0 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: valid=%b digit=%0d last=%b, required 0 0 0", out_valid, out_digit, out_last);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        got_d.delete(); got_l.delete();
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (got_d.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_residual: got %0d digits valid=%b, required 0 0", got_d.size(), out_valid);
        end
        beat(-3, -2, 1, 0);
        beat(0, 1, 0, 1);
        drain();
        n_checks++;
        if (got_d.size() != ed.size()) begin n_fail++; $display("FAIL midreset_count: got %0d digits, required %0d", got_d.size(), ed.size()); end
        for (int i = 0; i < ed.size() && i < got_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== ed[i] || got_l[i] !== el[i]) begin
                n_fail++;
                $display("FAIL midreset_digit%0d: got %0d last=%b, required %0d last=%b", i, got_d[i], got_l[i], ed[i], el[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ed[$] = '{1, -1, -1, -1, 1};
        bit el[$] = '{0, 1, 0, 0, 1};
        int c0;
        got_d.delete(); got_l.delete();
        beat(2, 1, 1, 1);
        c0 = cyc;
        beat(-3, -2, 1, 0);
        n_checks++;
        if (cyc - c0 !== 2) begin n_fail++; $display("FAIL b2b_gap: next frame accepted after %0d cycles, required 2", cyc - c0); end
        beat(0, 1, 0, 1);
        drain();
        n_checks++;
        if (got_d.size() != ed.size()) begin n_fail++; $display("FAIL b2b_count: got %0d digits, required %0d", got_d.size(), ed.size()); end
        for (int i = 0; i < ed.size() && i < got_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== ed[i] || got_l[i] !== el[i]) begin
                n_fail++;
                $display("FAIL b2b_digit%0d: got %0d last=%b, required %0d last=%b", i, got_d[i], got_l[i], ed[i], el[i]);
            end
        end
    endtask

`ifdef ONLINE_ADDER_RANGE_CHECK_EN
    task automatic test_range();
        beat(-4, 0, 1, 0);
        n_checks++;
        if (range_err !== 1'b1) begin n_fail++; $display("FAIL range_set: got %b, required 1", range_err); end
        beat(1, 1, 0, 1);
        drain();
        n_checks++;
        if (range_err !== 1'b1) begin n_fail++; $display("FAIL range_sticky: got %b, required 1", range_err); end
        beat(1, 0, 1, 1);
        n_checks++;
        if (range_err !== 1'b0) begin n_fail++; $display("FAIL range_clear: got %b, required 0", range_err); end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_discard_single();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
`ifdef ONLINE_ADDER_RANGE_CHECK_EN
        test_range();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
